// File: rtl/cmd_dispatch.sv
// Command dispatcher: decodes a UART command byte, enables one handler slot,
// muxes that handler's TX stream, and replies with a NAK byte for unknown commands.
module cmd_dispatch #(
    parameter int          NUM_CMD        = 4,
    parameter logic [7:0]  CMD_BASE       = 8'h01,
    parameter logic [7:0]  NAK_BYTE       = 8'hEE,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_ready,
    input  logic [7:0]  rx_data,
    input  logic        tx_active,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic [3:0]  activate,
    input  logic [3:0]  done,
    input  logic [3:0]  h_tx_start,
    input  logic [31:0] h_tx_data,
    output logic        busy,
    output logic        err_unknown,
    output logic        err_timeout
);

    typedef enum logic [1:0] {IDLE, ACTIVE, RELEASE, NAK} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  sel;
    logic [1:0]  sel_nxt;
    logic [23:0] timer;
    logic [23:0] timer_nxt;
    logic        rx_ready_q;
    logic        err_unknown_nxt;
    logic        err_timeout_nxt;
    logic        rx_rise;
    logic        cmd_valid;
    logic        sel_done;
    logic        timeout_hit;

    assign rx_rise     = rx_ready & ~rx_ready_q;
    // Range check in 9 bits so CMD_BASE+NUM_CMD cannot wrap past 8'hFF.
    assign cmd_valid   = ({1'b0, rx_data} >= {1'b0, CMD_BASE}) &&
                         ({1'b0, rx_data} < ({1'b0, CMD_BASE} + 9'(NUM_CMD)));
    assign sel_done    = done[sel];
    assign timeout_hit = (TIMEOUT_CYCLES != 24'd0) && (timer == TIMEOUT_CYCLES - 24'd1);
    assign busy        = (state != IDLE);

    always_comb begin
        state_nxt       = state;
        sel_nxt         = sel;
        timer_nxt       = timer;
        err_unknown_nxt = 1'b0;
        err_timeout_nxt = 1'b0;
        tx_start        = 1'b0;
        tx_data         = 8'h00;
        case (state)
            IDLE: begin
                if (rx_rise) begin
                    if (cmd_valid) begin
                        sel_nxt   = 2'(rx_data - CMD_BASE);
                        timer_nxt = 24'd0;
                        state_nxt = ACTIVE;
                    end else begin
                        err_unknown_nxt = 1'b1;
                        state_nxt       = NAK;
                    end
                end
            end
            ACTIVE: begin
                tx_start = h_tx_start[sel];
                tx_data  = h_tx_data[{sel, 3'b000} +: 8];
                // Completion has priority over a simultaneous timeout.
                if (sel_done) begin
                    state_nxt = RELEASE;
                end else if (timeout_hit) begin
                    err_timeout_nxt = 1'b1;
                    state_nxt       = RELEASE;
                end else if ((TIMEOUT_CYCLES != 24'd0) && (timer != 24'hFFFFFF)) begin
                    timer_nxt = timer + 24'd1;
                end
            end
            RELEASE: begin
                tx_start = h_tx_start[sel];
                tx_data  = h_tx_data[{sel, 3'b000} +: 8];
                if (!sel_done && !rx_ready && !tx_active) begin
                    state_nxt = IDLE;
                end
            end
            NAK: begin
                tx_data = NAK_BYTE;
                if (!tx_active) begin
                    tx_start  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // rx_ready_q resets high so a byte already pending at reset release is not a command.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            sel         <= 2'd0;
            timer       <= 24'd0;
            rx_ready_q  <= 1'b1;
            activate    <= 4'b0000;
            err_unknown <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            sel         <= sel_nxt;
            timer       <= timer_nxt;
            rx_ready_q  <= rx_ready;
            activate    <= (state_nxt == ACTIVE) ? (4'b0001 << sel_nxt) : 4'b0000;
            err_unknown <= err_unknown_nxt;
            err_timeout <= err_timeout_nxt;
        end
    end

endmodule

// File: tb/tb_cmd_dispatch.sv
// Bench for cmd_dispatch: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_cmd_dispatch;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_ready = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_active = 1'b0;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [3:0]  activate;
    logic [3:0]  done = 4'h0;
    logic [3:0]  h_tx_start = 4'h0;
    logic [31:0] h_tx_data = 32'h0;
    logic        busy;
    logic        err_unknown;
    logic        err_timeout;

    int total = 0;
    int bad = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    cmd_dispatch #(
        .NUM_CMD(4),
        .CMD_BASE(8'h01),
        .NAK_BYTE(8'hEE),
        .TIMEOUT_CYCLES(24'd16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx_ready(rx_ready),
        .rx_data(rx_data),
        .tx_active(tx_active),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .activate(activate),
        .done(done),
        .h_tx_start(h_tx_start),
        .h_tx_data(h_tx_data),
        .busy(busy),
        .err_unknown(err_unknown),
        .err_timeout(err_timeout)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Model: mode 0=idle, 1=handler running, 2=waiting for release, 3=sending NAK.
    int  m_mode = 0;
    int  m_sel = 0;
    int  m_age = 0;
    bit  m_prev_rx = 1'b1;
    bit  m_eu = 1'b0;
    bit  m_et = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode    <= 0;
            m_sel     <= 0;
            m_age     <= 0;
            m_prev_rx <= 1'b1;
            m_eu      <= 1'b0;
            m_et      <= 1'b0;
        end else begin
            m_eu      <= 1'b0;
            m_et      <= 1'b0;
            m_prev_rx <= rx_ready;
            case (m_mode)
                0: if (rx_ready && !m_prev_rx) begin
                    if (int'(rx_data) >= 1 && int'(rx_data) < 5) begin
                        m_sel  <= int'(rx_data) - 1;
                        m_age  <= 0;
                        m_mode <= 1;
                    end else begin
                        m_eu   <= 1'b1;
                        m_mode <= 3;
                    end
                end
                1: if (done[m_sel]) begin
                    m_mode <= 2;
                end else if (m_age + 1 == TMO) begin
                    m_mode <= 2;
                    m_et   <= 1'b1;
                end else begin
                    m_age <= m_age + 1;
                end
                2: if (!done[m_sel] && !rx_ready && !tx_active) m_mode <= 0;
                3: if (!tx_active) m_mode <= 0;
                default: m_mode <= 0;
            endcase
        end
    end

    logic [3:0] e_act;
    logic       e_ts;
    logic [7:0] e_td;

    always @(negedge clk) begin
        #2;
        if (check_en) begin
            e_act = (m_mode == 1) ? 4'(1 << m_sel) : 4'h0;
            e_ts  = 1'b0;
            e_td  = 8'h00;
            if (m_mode == 1 || m_mode == 2) begin
                e_ts = h_tx_start[m_sel];
                e_td = h_tx_data[8*m_sel +: 8];
            end else if (m_mode == 3) begin
                e_ts = !tx_active;
                e_td = 8'hEE;
            end
            check("model_activate", activate, e_act);
            check("model_busy", busy, m_mode != 0);
            check("model_tx_start", tx_start, e_ts);
            check("model_tx_data", tx_data, e_td);
            check("model_err_unknown", err_unknown, m_eu);
            check("model_err_timeout", err_timeout, m_et);
        end
    end

    int         eu_c, ts_c, ts_i, rise_c, drop_c;
    logic [7:0] ts_d;
    logic       et_at_drop;

    initial begin
        repeat (3) @(negedge clk);
        #3;
        check("reset_activate", activate, 4'h0);
        check("reset_busy", busy, 1'b0);
        check("reset_tx_start", tx_start, 1'b0);
        check("reset_tx_data", tx_data, 8'h00);
        check("reset_errs", {err_unknown, err_timeout}, 2'b00);
        check_en = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Valid command selects slot 1 and muxes its TX lane
        rx_data = 8'h02; rx_ready = 1'b1;
        h_tx_data = 32'h4433_3711; h_tx_start = 4'b0010;
        #3 check("cmd_busy_before", busy, 1'b0);
        @(negedge clk); #3;
        check("cmd_activate", activate, 4'b0010);
        check("cmd_tx_data", tx_data, 8'h37);
        check("cmd_tx_start", tx_start, 1'b1);

        // Second rx edge while active is ignored
        @(negedge clk); rx_ready = 1'b0;
        @(negedge clk); rx_ready = 1'b1; rx_data = 8'h03;
        @(negedge clk); #3;
        check("ignore_activate", activate, 4'b0010);
        check("ignore_tx_data", tx_data, 8'h37);

        // Completion then release
        @(negedge clk); rx_ready = 1'b0; done = 4'b0010;
        @(negedge clk); done = 4'b0000; #3;
        check("done_activate", activate, 4'h0);
        check("done_busy_release", busy, 1'b1);
        @(negedge clk); #3;
        check("release_idle", busy, 1'b0);

        // Unknown command while TX busy for 5 cycles
        @(negedge clk); tx_active = 1'b1; rx_data = 8'h09; rx_ready = 1'b1;
        eu_c = 0; ts_c = 0; ts_i = -1; ts_d = 8'h00;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tx_active = (i < 4);
            rx_ready = 1'b0;
            #3;
            if (err_unknown) eu_c++;
            if (tx_start) begin
                ts_c++;
                ts_i = i;
                ts_d = tx_data;
            end
        end
        check("nak_err_pulses", eu_c, 1);
        check("nak_tx_count", ts_c, 1);
        check("nak_tx_cycle", ts_i, 4);
        check("nak_tx_data", ts_d, 8'hEE);
        check("nak_idle", busy, 1'b0);

        // Timeout on slot 0
        @(negedge clk); rx_data = 8'h01; rx_ready = 1'b1; done = 4'h0;
        rise_c = -1; drop_c = -1; et_at_drop = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            rx_ready = 1'b0;
            #3;
            if (rise_c < 0 && activate == 4'b0001) begin
                rise_c = i;
            end else if (rise_c >= 0 && drop_c < 0 && activate == 4'h0) begin
                drop_c = i;
                et_at_drop = err_timeout;
            end
        end
        check("tmo_rise", rise_c, 0);
        check("tmo_length", drop_c - rise_c, 16);
        check("tmo_err_pulse", et_at_drop, 1'b1);
        check("tmo_idle", busy, 1'b0);

        // Asynchronous reset while active, rx_ready held high across it
        @(negedge clk); rx_data = 8'h03; rx_ready = 1'b1;
        @(negedge clk); #3 check("rst_pre_activate", activate, 4'b0100);
        @(negedge clk); #1 reset = 1'b1;
        #1 check("rst_async_activate", activate, 4'h0);
        check("rst_async_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #3;
            check("rst_no_accept", {busy, activate}, 5'b0);
        end
        @(negedge clk); rx_ready = 1'b0;
        @(negedge clk); rx_ready = 1'b1;
        @(negedge clk); #3 check("rst_reaccept", activate, 4'b0100);
        @(negedge clk); done = 4'b0100; rx_ready = 1'b0;
        @(negedge clk); done = 4'b0000;
        repeat (2) @(negedge clk);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 399) == 0) reset = 1'b1;
            if ($urandom_range(0, 3) == 0) rx_ready = ~rx_ready;
            case ($urandom_range(0, 7))
                0: rx_data = 8'h00;
                1: rx_data = 8'h01;
                2: rx_data = 8'h02;
                3: rx_data = 8'h03;
                4: rx_data = 8'h04;
                5: rx_data = 8'h05;
                6: rx_data = 8'hFF;
                default: rx_data = 8'($urandom);
            endcase
            tx_active = ($urandom_range(0, 2) == 0);
            for (int b = 0; b < 4; b++) done[b] = ($urandom_range(0, 7) == 0);
            h_tx_start = 4'($urandom);
            h_tx_data = $urandom;
        end
        @(negedge clk);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
